// File: rtl/sv_rand_arb.sv
// rtl/sv_rand_arb.sv - round-robin arbiter sharing one random source among signature cores
// Fetches one word per grant and delivers it once, or discards it on timeout or withdrawal.
module sv_rand_arb #(
    parameter int N_CORES    = 4,
    parameter int BLOCK_SIZE = 256,
    parameter int TIMEOUT    = 1024,
    localparam int GW        = $clog2(N_CORES)
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [N_CORES-1:0]    req_i,
    output logic [N_CORES-1:0]    ready_o,
    output logic [BLOCK_SIZE-1:0] rand_o,
    output logic                  trng_req_o,
    input  logic                  trng_ready_i,
    input  logic [BLOCK_SIZE-1:0] trng_data_i,
    output logic [GW-1:0]         grant_o,
    output logic                  busy_o,
    output logic                  err_o,
    input  logic                  clr_err_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [GW-1:0]         last_grant;
    logic [BLOCK_SIZE-1:0] buffer;
    logic [15:0]           cnt;
    logic                  withdrawn;

    logic                  pick_valid;
    logic [GW-1:0]         pick;
    logic [GW-1:0]         idx;
    int                    c;

    logic                  do_grant;
    logic                  do_capture;
    logic                  do_deliver;
    logic                  set_err;

    // Round-robin scan starting just after the last core that actually received a word
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        c          = 0;
        idx        = '0;
        for (int i = 1; i <= N_CORES; i++) begin
            c   = (int'(last_grant) + i) % N_CORES;
            idx = GW'(c);
            if (!pick_valid && req_i[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_capture = 1'b0;
        do_deliver = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    do_grant   = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (trng_ready_i) begin
                    do_capture = 1'b1;
                    // A core that let go of its request at any point forfeits this word
                    state_next = (withdrawn || !req_i[grant_o]) ? FLUSH : DELIVER;
                end else if (cnt == 16'(TIMEOUT - 1)) begin
                    set_err    = 1'b1;
                    state_next = FLUSH;
                end
            end
            DELIVER: begin
                do_deliver = 1'b1;
                state_next = FLUSH;
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            grant_o    <= '0;
            last_grant <= GW'(N_CORES - 1);
            buffer     <= '0;
            cnt        <= '0;
            withdrawn  <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            if (do_grant) begin
                grant_o   <= pick;
                cnt       <= '0;
                withdrawn <= 1'b0;
            end
            if (state == FETCH) begin
                cnt <= cnt + 16'd1;
                if (!req_i[grant_o]) begin
                    withdrawn <= 1'b1;
                end
            end
            if (do_capture) begin
                buffer <= trng_data_i;
            end
            if (state == FLUSH) begin
                buffer <= '0;
            end
            if (do_deliver) begin
                last_grant <= grant_o;
            end
            if (set_err) begin
                err_o <= 1'b1;
            end else if (clr_err_i) begin
                err_o <= 1'b0;
            end
        end
    end

    assign busy_o     = (state != IDLE);
    assign trng_req_o = (state == FETCH);
    assign ready_o    = (state == DELIVER) ? (N_CORES'(1) << grant_o) : '0;
    assign rand_o     = (state == DELIVER) ? buffer : '0;

endmodule
